// File: rtl/ex_hazard_ctrl_if.sv
// rtl/ex_hazard_ctrl_if.sv - hazard controller pipeline/memory handshake bundle
//
// Groups everything the hazard controller sees and drives except clk/rst_n.
//   slave  : used by ex_hazard_ctrl (pipeline/memory status in, controls out)
//   master : used by the pipeline / testbench (status out, controls in)
interface ex_hazard_ctrl_if;
  logic [3:0]  idex_opcode;
  logic [2:0]  idex_dr;
  logic        idex_regwrite;
  logic [2:0]  id_sr1;
  logic [2:0]  id_sr2;
  logic        id_check_sr1;
  logic        id_check_sr2;
  logic [3:0]  exmem_opcode;
  logic        branch_taken;
  logic        imem_read;
  logic        imem_resp;
  logic        dmem_access;
  logic        dmem_resp;
  logic        perf_clr;

  logic        pc_load;
  logic        ifid_load;
  logic        idex_load;
  logic        exmem_load;
  logic        memwb_load;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        pc_redirect;
  logic        dmem_phase;
  logic [15:0] stall_cycles;

  modport slave (
    input  idex_opcode, idex_dr, idex_regwrite, id_sr1, id_sr2,
           id_check_sr1, id_check_sr2, exmem_opcode, branch_taken,
           imem_read, imem_resp, dmem_access, dmem_resp, perf_clr,
    output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
           idex_bubble, ifid_flush, idex_flush, exmem_flush,
           pc_redirect, dmem_phase, stall_cycles
  );

  modport master (
    output idex_opcode, idex_dr, idex_regwrite, id_sr1, id_sr2,
           id_check_sr1, id_check_sr2, exmem_opcode, branch_taken,
           imem_read, imem_resp, dmem_access, dmem_resp, perf_clr,
    input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
           idex_bubble, ifid_flush, idex_flush, exmem_flush,
           pc_redirect, dmem_phase, stall_cycles
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - LC-3b pipeline stall/flush/bubble controller
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; also forces every control output low
//   hz    : ex_hazard_ctrl_if.slave - hazard inputs, memory handshakes,
//           load enables, flush/bubble/redirect, dmem_phase, stall_cycles
//
// States: RUN (normal), BUBBLE (one cycle after a load-use stall, hazard
// detection masked), IND2 (second data access of LDI/STI).
module ex_hazard_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  ex_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {RUN, BUBBLE, IND2} state_t;

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  state_t      state_q, state_d;
  logic [15:0] stall_q, stall_d;

  logic freeze;
  logic ind_start;
  logic is_load;
  logic src_match;
  logic hazard;

  assign freeze = (hz.dmem_access & ~hz.dmem_resp)
                | (hz.imem_read & ~hz.imem_resp)
                | ((state_q == IND2) & ~hz.dmem_resp);

  // First access of LDI/STI has completed: hold the pipeline one more cycle
  // and issue the second access from IND2.
  assign ind_start = (state_q != IND2) & hz.dmem_resp
                   & ((hz.exmem_opcode == OP_LDI) | (hz.exmem_opcode == OP_STI));

  assign is_load   = (hz.idex_opcode == OP_LDB) | (hz.idex_opcode == OP_LDR)
                   | (hz.idex_opcode == OP_LDI);
  assign src_match = (hz.id_check_sr1 & (hz.id_sr1 == hz.idex_dr))
                   | (hz.id_check_sr2 & (hz.id_sr2 == hz.idex_dr));
  // Masked in BUBBLE: the load has already moved on to EX/MEM.
  assign hazard    = is_load & hz.idex_regwrite & src_match & (state_q != BUBBLE);

  always_comb begin
    state_d        = state_q;
    hz.pc_load     = 1'b0;
    hz.ifid_load   = 1'b0;
    hz.idex_load   = 1'b0;
    hz.exmem_load  = 1'b0;
    hz.memwb_load  = 1'b0;
    hz.idex_bubble = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    hz.pc_redirect = 1'b0;
    hz.dmem_phase  = (state_q == IND2);

    if (rst_n) begin
      if (ind_start) begin
        state_d = IND2;
      end else if (freeze) begin
        state_d = state_q;
      end else if (hz.branch_taken) begin
        hz.pc_load     = 1'b1;
        hz.ifid_load   = 1'b1;
        hz.idex_load   = 1'b1;
        hz.exmem_load  = 1'b1;
        hz.memwb_load  = 1'b1;
        hz.pc_redirect = 1'b1;
        hz.ifid_flush  = 1'b1;
        hz.idex_flush  = 1'b1;
        hz.exmem_flush = 1'b1;
        state_d        = RUN;
      end else if (hazard) begin
        hz.idex_load   = 1'b1;
        hz.exmem_load  = 1'b1;
        hz.memwb_load  = 1'b1;
        hz.idex_bubble = 1'b1;
        state_d        = BUBBLE;
      end else begin
        hz.pc_load     = 1'b1;
        hz.ifid_load   = 1'b1;
        hz.idex_load   = 1'b1;
        hz.exmem_load  = 1'b1;
        hz.memwb_load  = 1'b1;
        state_d        = RUN;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hz.perf_clr) begin
      stall_d = 16'h0000;
    end else if (!hz.pc_load && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      stall_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign hz.stall_cycles = stall_q;

endmodule
